alu_issue_ctrl: RTL and testbench

- Driving end of the ALU datapath interface. Accepts an operation request (main-control ALU class, funct field, two register operands) over a valid/ready handshake.
- Decodes the request into the 3-bit ALU opcode and drives registered Ope1/Ope2/AluOp into the combinational ALU.
- Captures the returned Resultado/zero and presents them downstream over a second valid/ready handshake.
- Sits between the decode stage and writeback/branch logic in the processor.

---
 rtl/alu_issue_ctrl.sv | 158 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue side of the ALU datapath.
// Accepts an operation request over valid/ready, decodes it into a 3-bit ALU
// opcode, drives registered operands into the combinational ALU, captures the
// returned result/zero and presents them downstream over a second valid/ready.
// Optional feature: define ALU_ISSUE_BRANCH_EN to add the Branch_q output
// (branch-taken flag for beq-class requests).
module alu_issue_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       AluOpMain,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] RegA,
  input  logic [WIDTH-1:0] RegB,
  output logic [WIDTH-1:0] Ope1,
  output logic [WIDTH-1:0] Ope2,
  output logic [2:0]       AluOp,
  input  logic [WIDTH-1:0] Resultado,
  input  logic             zero,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Res_q,
  output logic             Zero_q,
`ifdef ALU_ISSUE_BRANCH_EN
  output logic             Branch_q,
`endif
  output logic             Err_q
);

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_AND = 3'b000;
  localparam logic [OP_W-1:0] OP_OR  = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD = 3'b010;
  localparam logic [OP_W-1:0] OP_XOR = 3'b011;
  localparam logic [OP_W-1:0] OP_NOR = 3'b100;
  localparam logic [OP_W-1:0] OP_SUB = 3'b110;
  localparam logic [OP_W-1:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t          state_q;
  logic            err_q;     // error flag of the op currently in flight
  logic [OP_W-1:0] dec_op;
  logic            dec_err;
  logic            accept;
`ifdef ALU_ISSUE_BRANCH_EN
  logic            is_beq_q;  // in-flight op came from the beq class
`endif

  // Decode the main-control class and funct field into an ALU opcode.
  always_comb begin
    dec_op  = OP_ADD;
    dec_err = 1'b0;
    unique case (AluOpMain)
      2'b00: dec_op = OP_ADD;
      2'b01: dec_op = OP_SUB;
      2'b10: begin
        unique case (Funct)
          6'b100000: dec_op = OP_ADD;
          6'b100010: dec_op = OP_SUB;
          6'b100100: dec_op = OP_AND;
          6'b100101: dec_op = OP_OR;
          6'b100110: dec_op = OP_XOR;
          6'b100111: dec_op = OP_NOR;
          6'b101010: dec_op = OP_SLT;
          default:   dec_err = 1'b1;
        endcase
      end
      default: dec_err = 1'b1;
    endcase
  end

  // Ready when idle, or when the held result is being taken this cycle.
  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      unique case (state_q)
        ST_IDLE: in_ready = 1'b1;
        ST_DONE: in_ready = out_ready;
        default: in_ready = 1'b0;
      endcase
    end
  end

  assign accept = in_valid & in_ready;

  // Issue/capture state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      Ope1      <= '0;
      Ope2      <= '0;
      AluOp     <= OP_AND;
      err_q     <= 1'b0;
      Res_q     <= '0;
      Zero_q    <= 1'b0;
      Err_q     <= 1'b0;
      out_valid <= 1'b0;
`ifdef ALU_ISSUE_BRANCH_EN
      is_beq_q  <= 1'b0;
      Branch_q  <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            Ope1    <= RegA;
            Ope2    <= RegB;
            AluOp   <= dec_op;
            err_q   <= dec_err;
`ifdef ALU_ISSUE_BRANCH_EN
            is_beq_q <= (AluOpMain == 2'b01);
`endif
            state_q <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          // Illegal requests report a clean zero result regardless of the ALU.
          Res_q     <= err_q ? '0 : Resultado;
          Zero_q    <= zero & ~err_q;
          Err_q     <= err_q;
`ifdef ALU_ISSUE_BRANCH_EN
          Branch_q  <= zero & is_beq_q & ~err_q;
`endif
          out_valid <= 1'b1;
          state_q   <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (accept) begin
              Ope1    <= RegA;
              Ope2    <= RegB;
              AluOp   <= dec_op;
              err_q   <= dec_err;
`ifdef ALU_ISSUE_BRANCH_EN
              is_beq_q <= (AluOpMain == 2'b01);
`endif
              state_q <= ST_EXEC;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU closing the loop.
module tb_alu_issue_ctrl;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   AluOpMain;
  logic [5:0]   Funct;
  logic [W-1:0] RegA, RegB;
  logic [W-1:0] Ope1, Ope2;
  logic [2:0]   AluOp;
  logic [W-1:0] Resultado;
  logic         zero;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Res_q;
  logic         Zero_q;
  logic         Err_q;
`ifdef ALU_ISSUE_BRANCH_EN
  logic         Branch_q;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .AluOpMain(AluOpMain), .Funct(Funct), .RegA(RegA), .RegB(RegB),
    .Ope1(Ope1), .Ope2(Ope2), .AluOp(AluOp),
    .Resultado(Resultado), .zero(zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .Res_q(Res_q), .Zero_q(Zero_q),
`ifdef ALU_ISSUE_BRANCH_EN
    .Branch_q(Branch_q),
`endif
    .Err_q(Err_q)
  );

  // Behavioural combinational ALU driven by the DUT operands.
  always_comb begin
    case (AluOp)
      3'b000:  Resultado = Ope1 & Ope2;
      3'b001:  Resultado = Ope1 | Ope2;
      3'b010:  Resultado = Ope1 + Ope2;
      3'b011:  Resultado = Ope1 ^ Ope2;
      3'b100:  Resultado = ~(Ope1 | Ope2);
      3'b110:  Resultado = Ope1 - Ope2;
      3'b111:  Resultado = ($signed(Ope1) < $signed(Ope2)) ? 32'd1 : 32'd0;
      default: Resultado = '0;
    endcase
    zero = (Resultado == '0);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic [1:0] m, input logic [5:0] f,
                           input logic [W-1:0] a, input logic [W-1:0] b);
    in_valid  = 1'b1;
    AluOpMain = m;
    Funct     = f;
    RegA      = a;
    RegB      = b;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    AluOpMain = 2'b00; Funct = 6'd0; RegA = '0; RegB = '0;
    step(); step();
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if ({Ope1, Ope2, Res_q} !== {3*W{1'b0}}) begin errors++; $display("FAIL reset_regs got %h %h %h want 0", Ope1, Ope2, Res_q); end
    checks++; if ({AluOp, Zero_q, Err_q} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b %b %b want 0", AluOp, Zero_q, Err_q); end
`ifdef ALU_ISSUE_BRANCH_EN
    checks++; if (Branch_q !== 1'b0) begin errors++; $display("FAIL reset_branch got %b want 0", Branch_q); end
`endif
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    drive_req(2'b10, 6'b100000, 32'd5, 32'd7);
    step();
    in_valid = 1'b0;
    checks++; if (AluOp !== 3'b010) begin errors++; $display("FAIL add_aluop got %b want 010", AluOp); end
    checks++; if (Ope1 !== 32'd5 || Ope2 !== 32'd7) begin errors++; $display("FAIL add_opes got %0d %0d want 5 7", Ope1, Ope2); end
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL add_exec got ov=%b ir=%b want 0 0", out_valid, in_ready); end
    step();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_out_valid got %b want 1", out_valid); end
    checks++; if (Res_q !== 32'd12 || Zero_q !== 1'b0 || Err_q !== 1'b0) begin errors++; $display("FAIL add_result got %0d z=%b e=%b want 12 0 0", Res_q, Zero_q, Err_q); end
    step();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL add_drain got ov=%b ir=%b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_beq();
    out_ready = 1'b1;
    drive_req(2'b01, 6'b111111, 32'hDEADBEEF, 32'hDEADBEEF);
    step();
    in_valid = 1'b0;
    checks++; if (AluOp !== 3'b110) begin errors++; $display("FAIL beq_aluop got %b want 110", AluOp); end
    step();
    checks++; if (Res_q !== 32'd0 || Zero_q !== 1'b1 || Err_q !== 1'b0) begin errors++; $display("FAIL beq_result got %h z=%b e=%b want 0 1 0", Res_q, Zero_q, Err_q); end
`ifdef ALU_ISSUE_BRANCH_EN
    checks++; if (Branch_q !== 1'b1) begin errors++; $display("FAIL beq_branch got %b want 1", Branch_q); end
`endif
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive_req(2'b10, 6'b101010, 32'd3, 32'd9);
    step();
    drive_req(2'b10, 6'b100111, 32'd0, 32'd0);
    step();
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b1 || Res_q !== 32'd1) begin errors++; $display("FAIL bp_hold%0d got ov=%b res=%0d want 1 1", i, out_valid, Res_q); end
      checks++; if (in_ready !== 1'b0 || Ope1 !== 32'd3 || AluOp !== 3'b111) begin errors++; $display("FAIL bp_block%0d got ir=%b ope1=%0d op=%b want 0 3 111", i, in_ready, Ope1, AluOp); end
      step();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || AluOp !== 3'b100 || Ope1 !== 32'd0) begin errors++; $display("FAIL b2b_accept got ov=%b op=%b ope1=%0d want 0 100 0", out_valid, AluOp, Ope1); end
    step();
    checks++; if (out_valid !== 1'b1 || Res_q !== 32'hFFFFFFFF || Zero_q !== 1'b0) begin errors++; $display("FAIL b2b_nor got ov=%b res=%h z=%b want 1 ffffffff 0", out_valid, Res_q, Zero_q); end
    step();
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    drive_req(2'b10, 6'b000111, 32'd1, 32'd2);
    step();
    in_valid = 1'b0;
    checks++; if (AluOp !== 3'b010) begin errors++; $display("FAIL ill_funct_aluop got %b want 010", AluOp); end
    step();
    checks++; if (Err_q !== 1'b1 || Res_q !== 32'd0 || Zero_q !== 1'b0) begin errors++; $display("FAIL ill_funct got e=%b res=%0d z=%b want 1 0 0", Err_q, Res_q, Zero_q); end
    drive_req(2'b11, 6'b100000, 32'd0, 32'd0);
    step();
    in_valid = 1'b0;
    step();
    checks++; if (Err_q !== 1'b1 || Res_q !== 32'd0 || Zero_q !== 1'b0 || out_valid !== 1'b1) begin errors++; $display("FAIL ill_main got e=%b res=%0d z=%b ov=%b want 1 0 0 1", Err_q, Res_q, Zero_q, out_valid); end
`ifdef ALU_ISSUE_BRANCH_EN
    checks++; if (Branch_q !== 1'b0) begin errors++; $display("FAIL ill_branch got %b want 0", Branch_q); end
`endif
    step();
  endtask

  task automatic test_reset_midop();
    out_ready = 1'b0;
    drive_req(2'b10, 6'b100000, 32'd5, 32'd7);
    step();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready got %b want 0", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0 || Ope1 !== 32'd0 || AluOp !== 3'b000 || Err_q !== 1'b0) begin errors++; $display("FAIL rst_mid_clear got ov=%b ope1=%0d op=%b e=%b want 0 0 000 0", out_valid, Ope1, AluOp, Err_q); end
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_idle got %b want 1", in_ready); end
    out_ready = 1'b1;
    drive_req(2'b00, 6'b000000, 32'd10, 32'd20);
    step();
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b1 || Res_q !== 32'd30 || Err_q !== 1'b0) begin errors++; $display("FAIL rst_mid_fresh got ov=%b res=%0d e=%b want 1 30 0", out_valid, Res_q, Err_q); end
    step();
  endtask

  initial begin
    test_reset();
    test_add();
    test_beq();
    test_back_to_back();
    test_illegal();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
